// File: rtl/bas_pkg.sv
// Shared constants for the binary adder/subtracter: default width and mode encoding.
package bas_pkg;

  localparam int   BAS_WIDTH = 4;
  localparam logic ADD       = 1'b0;
  localparam logic SUB       = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the adder/subtracter chains WIDTH of these into a ripple.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/binary_adder_subtracter.sv
// Registered two's-complement add/sub with signed-overflow flag.
// Define BAS_SATURATE_EN to clamp the result on signed overflow instead of wrapping.
module binary_adder_subtracter
  import bas_pkg::*;
#(
  parameter int WIDTH = BAS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] sum,
  output logic             v
);

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] next_sum;
  logic [WIDTH:0]   carry;
  logic             v_raw;

  // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
  assign sub_mode = (s == SUB);
  assign b_eff    = b ^ {WIDTH{sub_mode}};
  assign carry[0] = sub_mode;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .s    (raw_sum[i]),
      .cout (carry[i+1])
    );
  end

  assign v_raw = carry[WIDTH] ^ carry[WIDTH-1];

`ifdef BAS_SATURATE_EN
  // NOTE: next_sum gets a default before the conditional override so no latch is inferred.
  always_comb begin
    next_sum = raw_sum;
    if (v_raw) begin
      // Overflow only occurs with equal operand signs, so a's sign gives the direction.
      next_sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign next_sum = raw_sum;
`endif

  // NOTE: registers use non-blocking assignments; reset is synchronous and wins over the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      v   <= 1'b0;
    end else begin
      sum <= next_sum;
      v   <= v_raw;
    end
  end

endmodule

// File: tb/tb_binary_adder_subtracter.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against a signed-arithmetic model.
// Honours BAS_SATURATE_EN when defined for the build.
module tb_binary_adder_subtracter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a4, b4, sum4;
  logic       s4, v4;
  logic [7:0] a8, b8, sum8;
  logic       s8, v8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_adder_subtracter #(.WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .a (a4), .b (b4), .s (s4), .sum (sum4), .v (v4)
  );

  binary_adder_subtracter #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .a (a8), .b (b8), .s (s8), .sum (sum8), .v (v8)
  );

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: plain integer arithmetic with range check; returns {overflow, sum[7:0]}.
  function automatic logic [8:0] ref_op(input int w, input int av, input int bv, input logic sub);
    int r, max_v, min_v, mask;
    logic ovf;
    r     = sub ? av - bv : av + bv;
    max_v = (1 << (w - 1)) - 1;
    min_v = -(1 << (w - 1));
    mask  = (1 << w) - 1;
    ovf   = (r > max_v) || (r < min_v);
`ifdef BAS_SATURATE_EN
    if (ovf) r = (r > max_v) ? max_v : min_v;
`endif
    return {ovf, 8'(r & mask)};
  endfunction

  logic [3:0] e_sum4;
  logic       e_v4;
  logic [7:0] e_sum8;
  logic       e_v8;
  logic       model_valid = 1'b0;
  logic [8:0] r4, r8;

  always @(posedge clk) begin
    r4 = ref_op(4, int'($signed(a4)), int'($signed(b4)), s4);
    r8 = ref_op(8, int'($signed(a8)), int'($signed(b8)), s8);
    if (rst) begin
      e_sum4 <= '0; e_v4 <= 1'b0;
      e_sum8 <= '0; e_v8 <= 1'b0;
    end else begin
      e_sum4 <= r4[3:0]; e_v4 <= r4[8];
      e_sum8 <= r8[7:0]; e_v8 <= r8[8];
    end
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_sum4", {4'h0, sum4}, {4'h0, e_sum4});
      check("model_v4",   {7'h0, v4},   {7'h0, e_v4});
      check("model_sum8", sum8,         e_sum8);
      check("model_v8",   {7'h0, v8},   {7'h0, e_v8});
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [3:0] sum;
    logic       v;
  } op_t;

  localparam int NOPS = 7;
  op_t tbl [NOPS];

  initial begin
`ifdef BAS_SATURATE_EN
    tbl[0] = '{4'h7, 4'h1, 1'b0, 4'h7, 1'b1};
    tbl[4] = '{4'h4, 4'h6, 1'b0, 4'h7, 1'b1};
    tbl[5] = '{4'hC, 4'hA, 1'b0, 4'h8, 1'b1};
    tbl[6] = '{4'h0, 4'h8, 1'b1, 4'h7, 1'b1};
`else
    tbl[0] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b1};
    tbl[4] = '{4'h4, 4'h6, 1'b0, 4'hA, 1'b1};
    tbl[5] = '{4'hC, 4'hA, 1'b0, 4'h6, 1'b1};
    tbl[6] = '{4'h0, 4'h8, 1'b1, 4'h8, 1'b1};
`endif
    tbl[1] = '{4'h1, 4'h3, 1'b0, 4'h4, 1'b0};
    tbl[2] = '{4'h4, 4'h2, 1'b1, 4'h2, 1'b0};
    tbl[3] = '{4'h2, 4'h4, 1'b1, 4'hE, 1'b0};

    // Reset with live operands that would otherwise overflow.
    @(negedge clk);
    rst = 1'b1; a4 = 4'h7; b4 = 4'h1; s4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; s8 = 1'b0;
    @(negedge clk);
    check("reset_sum4", {4'h0, sum4}, 8'h00);
    check("reset_v4",   {7'h0, v4},   8'h00);
    check("reset_sum8", sum8,         8'h00);
    check("reset_v8",   {7'h0, v8},   8'h00);
    rst = 1'b0;
    a8 = 8'h7F; b8 = 8'h01; s8 = 1'b0;

    // Directed ops back to back; each result is checked one cycle after its operands.
    for (int i = 0; i <= NOPS; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check($sformatf("op%0d_sum", i - 1), {4'h0, sum4}, {4'h0, tbl[i-1].sum});
        check($sformatf("op%0d_v", i - 1),   {7'h0, v4},   {7'h0, tbl[i-1].v});
      end
      if (i == 1) begin
`ifdef BAS_SATURATE_EN
        check("w8_sum", sum8, 8'h7F);
`else
        check("w8_sum", sum8, 8'h80);
`endif
        check("w8_v", {7'h0, v8}, 8'h01);
      end
      if (i < NOPS) begin
        a4 = tbl[i].a; b4 = tbl[i].b; s4 = tbl[i].s;
      end
      if (i >= 1) begin
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      end
    end

    // Mid-stream reset discards the in-flight result.
    a4 = 4'h4; b4 = 4'h6; s4 = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_sum4", {4'h0, sum4}, 8'h00);
    check("midrst_v4",   {7'h0, v4},   8'h00);
    rst = 1'b0;

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      rst = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
